// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store stage.
// master: the load/store unit's view; slave: the surrounding pipeline and memory.
interface mem_access_unit_if;
    logic        in_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  in_valid, is_load, is_store, funct3, alu_out, rs2_data,
        output stall, ld_valid, ld_data, misaligned, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output in_valid, is_load, is_store, funct3, alu_out, rs2_data,
        input  stall, ld_valid, ld_data, misaligned, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: one outstanding req/ready memory transaction with load extension,
// store lane steering and timeout abort. Define MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_st_q, is_st_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic               req_q, req_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ld_valid_q, ld_valid_d;
    logic [31:0]        ld_data_q, ld_data_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;
    logic               stall_c;
    logic               mis_c;
    logic               mem_op_c;
    logic [3:0]         we_c;
    logic [31:0]        wdata_c;
    logic [7:0]         rd_byte_c;
    logic [15:0]        rd_half_c;
    logic [31:0]        ext_c;

`ifdef MISALIGN_TRAP_EN
    assign mis_c = ((bus.funct3[1:0] == 2'b01) && bus.alu_out[0]) ||
                   (bus.funct3[1] && (bus.alu_out[1:0] != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    assign mem_op_c = bus.in_valid && (bus.is_load || bus.is_store);

    // Store lane steering and load extension helpers
    always_comb begin
        we_c      = 4'hF;
        wdata_c   = bus.rs2_data;
        case (bus.funct3[1:0])
            2'b00: begin
                we_c    = 4'(4'b0001 << bus.alu_out[1:0]);
                wdata_c = {4{bus.rs2_data[7:0]}};
            end
            2'b01: begin
                we_c    = 4'(4'b0011 << {bus.alu_out[1], 1'b0});
                wdata_c = {2{bus.rs2_data[15:0]}};
            end
            default: ;
        endcase

        rd_byte_c = 8'(bus.mem_rdata >> {off_q, 3'b000});
        rd_half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            3'b001:  ext_c = {{16{rd_half_c[15]}}, rd_half_c};
            3'b100:  ext_c = {24'h0, rd_byte_c};
            3'b101:  ext_c = {16'h0, rd_half_c};
            default: ext_c = bus.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_st_d    = is_st_q;
        f3_d       = f3_q;
        off_d      = off_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ld_valid_d = 1'b0;
        ld_data_d  = ld_data_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    if (mis_c) begin
                        mis_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                        cnt_d   = '0;
                        is_st_d = bus.is_store;
                        f3_d    = bus.funct3;
                        off_d   = bus.alu_out[1:0];
                        req_d   = 1'b1;
                        we_d    = bus.is_store ? we_c : 4'h0;
                        addr_d  = {bus.alu_out[31:2], 2'b00};
                        wdata_d = wdata_c;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 4'h0;
                    if (!is_st_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = ext_c;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 4'h0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Inputs still hold the completed op here, so nothing is accepted.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_st_q    <= 1'b0;
            f3_q       <= 3'h0;
            off_q      <= 2'h0;
            req_q      <= 1'b0;
            we_q       <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_st_q    <= is_st_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.ld_valid   = ld_valid_q;
    assign bus.ld_data    = ld_data_q;
    assign bus.misaligned = mis_q;
    assign bus.bus_err    = berr_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store stage directly downstream of the execute ALU: takes the ALU result as the effective address plus the rs2 store operand, runs a single outstanding request/ready transaction against the data memory port, and returns sign/zero-extended load data to writeback. It also produces the pipeline stall that holds upstream stages while a transaction is outstanding. Non-memory instructions pass through without any effect on this block.

## Interface
Parameters:
- TIMEOUT, 255, max cycles waiting for mem_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  instruction present in this stage.
- is_load  input  1  instruction is a load.
- is_store  input  1  instruction is a store.
- funct3  input  3  RISC-V size/sign field.
- alu_out  input  32  effective address from the ALU.
- rs2_data  input  32  store operand.
- stall  output  1  hold upstream stages and keep inputs stable.
- ld_valid  output  1  one-cycle pulse, ld_data valid.
- ld_data  output  32  extended load result.
- misaligned  output  1  one-cycle pulse, access rejected.
- bus_err  output  1  one-cycle pulse, timeout abort.
- mem_req  output  1  request, held until mem_ready.
- mem_we  output  4  byte write enables, 0 for loads.
- mem_addr  output  32  word-aligned address, {alu_out[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  memory accepts the request and returns mem_rdata in the same cycle.
- mem_rdata  input  32  read word.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: when in_valid & (is_load|is_store), latch address, funct3, store data, and load/store flag; go to BUSY. If the access is misaligned (with MISALIGN_TRAP_EN), pulse misaligned next cycle, stay in IDLE, and issue no request. If both is_load and is_store are asserted, treat the op as a store.
- BUSY: mem_req=1 with stable addr/we/wdata. When mem_ready=1, capture the extended load data and go to DONE. If the counter reaches TIMEOUT without mem_ready, drop mem_req, pulse bus_err, and go to IDLE.
- DONE: ld_valid=1 for loads, 0 for stores. Inputs are ignored because they still hold the completed op. Next state is IDLE.
- Load extension by funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. Byte lane is addr[1:0]; halfword lane is addr[1]. Codes 011/110/111 are treated as word.
- Store by funct3: SB sets we=1<<addr[1:0] and wdata={4{rs2[7:0]}}. SH sets we=4'b0011<<{addr[1],1'b0} and wdata={2{rs2[15:0]}}. SW sets we=4'hF and wdata=rs2.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.

## Timing
- Reset values: stall=0, ld_valid=0, ld_data=0, misaligned=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, timeout counter 0.
- stall is combinational. It is 1 in IDLE on an accepted memory op (excluding the misaligned reject) and 1 throughout BUSY. It is 0 in DONE and 0 on the misaligned reject.
- Minimum latency: accept in cycle 0, mem_req in cycle 1, mem_ready in cycle 1, ld_valid in cycle 2. Each wait cycle adds one cycle.
- The timeout counter clears on entry to BUSY and increments each BUSY cycle without mem_ready. Abort occurs when count==TIMEOUT-1 with no ready. If mem_ready arrives on that same cycle, it wins and no abort occurs.
- At most one outstanding transaction; no new request is accepted until the FSM returns to IDLE.
- Reset mid-operation clears mem_req and all pulses immediately and discards the transaction.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned accesses are rejected as described under Operation (misaligned pulse, no request, stall=0).
- MISALIGN_TRAP_EN undefined: misaligned is tied to 0 and the access proceeds. A halfword uses the lane selected by addr[1]; a word ignores addr[1:0].

## Test plan
- LB at 0x1003, mem_rdata=0x80_00_00_00, ready same cycle: ld_data=0xFFFFFF80; ld_valid two cycles after accept.
- LHU at 0x2002, rdata=0xBEEF1234, 3 wait cycles: mem_req held for 4 cycles, ld_data=0x0000BEEF, stall low only in DONE.
- SB at 0x11, rs2=0x000000A5: mem_we=4'b0010, mem_wdata=0xA5A5A5A5, mem_addr=0x10, ld_valid=0.
- SW at 0x102 with MISALIGN_TRAP_EN defined: misaligned pulse, mem_req never rises. Without the macro: mem_addr=0x100, mem_we=4'hF.
- TIMEOUT=4 with mem_ready held low: bus_err pulses after 4 BUSY cycles, mem_req drops, FSM returns to IDLE. A variant with ready on the 4th cycle completes normally.
- Assert rst in the 2nd BUSY cycle: mem_req=0 immediately, no ld_valid, and the next load after reset completes normally.
